coin_acceptor: RTL

COIN_ACCEPTOR -- requirements
Module: coin_acceptor

---
 rtl/coin_acceptor_pkg.sv | 32 +++
 rtl/coin_acceptor_sync2.sv | 26 ++
 rtl/coin_acceptor.sv | 139 +++++++++++++
 3 files changed

// File: rtl/coin_acceptor_pkg.sv
// coin_acceptor_pkg -- shared definitions for the coin acceptor and the
// vending FSM it feeds.
//   COIN_*      : coin codes carried on the 2-bit coin bus (11 is never used)
//   state_e     : coin acceptor FSM state encoding
//   coin_value  : monetary value of a coin code, for credit accumulation
package coin_acceptor_pkg;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_5    = 2'b01;
  localparam logic [1:0] COIN_10   = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_QUAL5    = 3'd1,
    ST_QUAL10   = 3'd2,
    ST_REJECT   = 3'd3,
    ST_RELEASE  = 3'd4,
    ST_GAP_WAIT = 3'd5
  } state_e;

  // Value in coin units of a code on the coin bus; unused codes are worth 0.
  function automatic logic [4:0] coin_value(input logic [1:0] code);
    logic [4:0] val;
    case (code)
      COIN_5:  val = 5'd5;
      COIN_10: val = 5'd10;
      default: val = 5'd0;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/coin_acceptor_sync2.sv
// coin_sync2 -- two-flop synchronizer for one raw asynchronous sensor.
//   clk : sampling clock
//   rst : asynchronous active-high reset, clears both flops
//   d   : raw asynchronous input
//   q   : synchronized output, two clk edges after d
module coin_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_r;

  // Two-stage capture; meta_r may go metastable and gets a full cycle to settle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_r <= 1'b0;
      q      <= 1'b0;
    end else begin
      meta_r <= d;
      q      <= meta_r;
    end
  end

endmodule

// File: rtl/coin_acceptor.sv
// coin_acceptor -- debounces two bouncy coin sensors and reports one coin code
// per insertion to the vending FSM.
//   clk      : single clock, rising edge
//   rst      : asynchronous active-high reset
//   sense_5  : raw 5-unit coin sensor (asynchronous, bouncy)
//   sense_10 : raw 10-unit coin sensor (asynchronous, bouncy)
//   coin     : registered one-cycle coin code (COIN_NONE/COIN_5/COIN_10)
//   reject   : registered one-cycle pulse when an ambiguous insertion is dropped
//   busy     : registered, high whenever the FSM is not idle
// Parameters: DEBOUNCE (2..15) qualifying high samples, GAP (1..15) quiet
// samples required after release before the next insertion is accepted.
module coin_acceptor
  import coin_acceptor_pkg::*;
#(
  parameter int unsigned DEBOUNCE = 4,
  parameter int unsigned GAP      = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sense_5,
  input  logic       sense_10,
  output logic [1:0] coin,
  output logic       reject,
  output logic       busy
);

  localparam logic [3:0] DEB_C = 4'(DEBOUNCE);
  localparam logic [3:0] GAP_C = 4'(GAP);

  logic       s5_s;
  logic       s10_s;
  logic       own_s;
  logic       other_s;
  logic [1:0] own_code_s;
  state_e     state_r;
  state_e     state_s;
  logic [3:0] count_r;
  logic [3:0] count_s;
  logic [1:0] coin_s;
  logic       reject_s;

  coin_sync2 u_sync5  (.clk(clk), .rst(rst), .d(sense_5),  .q(s5_s));
  coin_sync2 u_sync10 (.clk(clk), .rst(rst), .d(sense_10), .q(s10_s));

  // In a qualify state, pick which synced sensor is "own" and which is "other".
  always_comb begin
    if (state_r == ST_QUAL10) begin
      own_s      = s10_s;
      other_s    = s5_s;
      own_code_s = COIN_10;
    end else begin
      own_s      = s5_s;
      other_s    = s10_s;
      own_code_s = COIN_5;
    end
  end

  // Next-state, shared counter and next output values.
  always_comb begin
    state_s  = state_r;
    count_s  = 4'd0;
    coin_s   = COIN_NONE;
    reject_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (s5_s && s10_s) begin
          state_s  = ST_REJECT;
          reject_s = 1'b1;
        end else if (s5_s) begin
          state_s = ST_QUAL5;
          count_s = 4'd1;
        end else if (s10_s) begin
          state_s = ST_QUAL10;
          count_s = 4'd1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_QUAL5, ST_QUAL10: begin
        if (other_s) begin
          state_s  = ST_REJECT;
          reject_s = 1'b1;
        end else if (own_s) begin
          // The sample that would make count equal DEBOUNCE emits the coin.
          if (count_r + 4'd1 == DEB_C) begin
            state_s = ST_RELEASE;
            coin_s  = own_code_s;
          end else begin
            count_s = count_r + 4'd1;
          end
        end else begin
          // Short pulse: treated as a glitch, silently dropped.
          state_s = ST_IDLE;
        end
      end
      ST_REJECT: begin
        state_s = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (!s5_s && !s10_s) begin
          state_s = ST_GAP_WAIT;
          count_s = 4'd1;
        end else begin
          state_s = ST_RELEASE;
        end
      end
      ST_GAP_WAIT: begin
        if (s5_s || s10_s) begin
          state_s = ST_RELEASE;
        end else if (count_r + 4'd1 >= GAP_C) begin
          state_s = ST_IDLE;
        end else begin
          count_s = count_r + 4'd1;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, counter and all outputs are registered so no sensor path reaches a pin.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      count_r <= 4'd0;
      coin    <= COIN_NONE;
      reject  <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state_r <= state_s;
      count_r <= count_s;
      coin    <= coin_s;
      reject  <= reject_s;
      busy    <= (state_s != ST_IDLE);
    end
  end

endmodule
